// File: rtl/dmni_send_pkg.sv
// Shared types and defaults for the DMNI send-side DMA engine.
package DMNIPkg;

  localparam int FLIT_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ_1,
    READ_2,
    DRAIN
  } send_state_t;

endpackage

// File: rtl/dmni_fifo.sv
// Synchronous FIFO with occupancy count; depth must be a power of two so
// the pointers wrap naturally.
module dmni_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage is deliberately not reset; only the pointers and count
  // define validity, which keeps this a plain RAM without a reset tree.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dmni_send.sv
// Send-side DMA of the DMNI: reads up to two memory segments and streams
// them as flits onto the router local port under credit flow control.
module dmni_send
  import DMNIPkg::*;
#(
  parameter int BUFFER_SIZE = 16,
  parameter int FLIT_SIZE   = DMNIPkg::FLIT_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          size_i,
  input  logic [31:0]          address_i,
  input  logic [31:0]          size_2_i,
  input  logic [31:0]          address_2_i,
  output logic                 send_active_o,
  output logic                 mem_en_o,
  output logic [31:0]          mem_addr_o,
  input  logic [FLIT_SIZE-1:0] mem_data_i,
  output logic                 noc_tx_o,
  output logic [FLIT_SIZE-1:0] noc_data_o,
  input  logic                 noc_credit_i
);

  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  send_state_t state_q, state_d;
  logic [31:0] rem1_q, rem1_d, addr1_q, addr1_d;
  logic [31:0] rem2_q, rem2_d, addr2_q, addr2_d;
  logic        inflight_q, inflight_d;
  logic        active_q, active_d;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty, fifo_full;
  logic [FLIT_SIZE-1:0] fifo_head;
  logic [CW:0]          occupancy;
  logic [31:0]          cur_rem, cur_addr;
  logic                 reading, room, issue, pop;

  // Space is reserved for an in-flight read so the unconditional capture
  // one cycle later can never overflow the FIFO.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign room      = !fifo_full && (occupancy < (CW+1)'(BUFFER_SIZE));
  assign reading   = (state_q == READ_1) || (state_q == READ_2);
  assign cur_rem   = (state_q == READ_2) ? rem2_q  : rem1_q;
  assign cur_addr  = (state_q == READ_2) ? addr2_q : addr1_q;
  assign issue     = reading && (cur_rem != '0) && room;

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    rem1_d     = rem1_q;
    addr1_d    = addr1_q;
    rem2_d     = rem2_q;
    addr2_d    = addr2_q;
    inflight_d = issue;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          rem1_d  = size_i;
          addr1_d = address_i;
          rem2_d  = size_2_i;
          addr2_d = address_2_i;
          if (size_i != '0)        state_d = READ_1;
          else if (size_2_i != '0) state_d = READ_2;
        end
      end
      READ_1: begin
        if (issue) begin
          rem1_d  = rem1_q - 32'd1;
          addr1_d = addr1_q + 32'd4;
          if (rem1_q == 32'd1) state_d = (rem2_q != '0) ? READ_2 : DRAIN;
        end
      end
      READ_2: begin
        if (issue) begin
          rem2_d  = rem2_q - 32'd1;
          addr2_d = addr2_q + 32'd4;
          if (rem2_q == 32'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rem1_q     <= '0;
      addr1_q    <= '0;
      rem2_q     <= '0;
      addr2_q    <= '0;
      inflight_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem1_q     <= rem1_d;
      addr1_q    <= addr1_d;
      rem2_q     <= rem2_d;
      addr2_q    <= addr2_d;
      inflight_q <= inflight_d;
      active_q   <= active_d;
    end
  end

  assign pop = noc_tx_o && noc_credit_i;

  dmni_fifo #(
    .DEPTH (BUFFER_SIZE),
    .WIDTH (FLIT_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .data_i  (mem_data_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign send_active_o = active_q;
  assign mem_en_o      = issue;
  assign mem_addr_o    = reading ? cur_addr : '0;
  assign noc_tx_o      = !fifo_empty;
  assign noc_data_o    = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_dmni_send.sv
// Self-checking bench for dmni_send: a queue-based transfer model is compared
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_dmni_send;

  localparam int BS = 16;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] size_i = '0, address_i = '0, size_2_i = '0, address_2_i = '0;
  logic        send_active_o, mem_en_o, noc_tx_o;
  logic [31:0] mem_addr_o, noc_data_o;
  logic [31:0] mem_data_i;
  logic        noc_credit_i;

  dmni_send #(.BUFFER_SIZE(BS), .FLIT_SIZE(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .size_i        (size_i),
    .address_i     (address_i),
    .size_2_i      (size_2_i),
    .address_2_i   (address_2_i),
    .send_active_o (send_active_o),
    .mem_en_o      (mem_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_i    (mem_data_i),
    .noc_tx_o      (noc_tx_o),
    .noc_data_o    (noc_data_o),
    .noc_credit_i  (noc_credit_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: returns the word one cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_data_i <= mem_en_o ? word_at(mem_addr_o) : $urandom;

  // Credit driver: fixed level or random, chosen by the stimulus.
  bit   rand_credit = 1'b0;
  logic credit_fix  = 1'b1;
  initial noc_credit_i = 1'b1;
  always @(posedge clk) begin
    #2;
    noc_credit_i = rand_credit ? ($urandom_range(0, 3) != 0) : credit_fix;
  end

  // Transfer model: phase 0 idle, 1/2 reading segment 1/2, 3 draining.
  int          m_phase;
  logic [31:0] m_rem1, m_addr1, m_rem2, m_addr2, m_pend;
  bit          m_infl;
  logic [31:0] m_q[$];
  logic [31:0] got[$];
  int          reads;

  bit          c_read, c_en, c_tx, c_pop, c_empty, c_infl;
  logic [31:0] c_rem, c_addr;

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_phase = 0; m_rem1 = '0; m_addr1 = '0; m_rem2 = '0; m_addr2 = '0;
      m_infl = 1'b0; m_pend = '0;
      m_q.delete();
    end else begin
      c_read = (m_phase == 1) || (m_phase == 2);
      c_rem  = (m_phase == 2) ? m_rem2  : m_rem1;
      c_addr = (m_phase == 2) ? m_addr2 : m_addr1;
      c_en   = c_read && (c_rem != 0) && ((m_q.size() + int'(m_infl)) < BS);
      c_tx   = (m_q.size() != 0);

      check("send_active", {31'b0, send_active_o}, {31'b0, m_phase != 0});
      check("mem_en",      {31'b0, mem_en_o},      {31'b0, c_en});
      check("mem_addr",    mem_addr_o,             c_read ? c_addr : 32'h0);
      check("noc_tx",      {31'b0, noc_tx_o},      {31'b0, c_tx});
      check("noc_data",    noc_data_o,             c_tx ? m_q[0] : 32'h0);

      if (noc_tx_o && noc_credit_i) got.push_back(noc_data_o);
      if (mem_en_o) reads++;

      c_pop   = c_tx && noc_credit_i;
      c_empty = !c_tx;
      c_infl  = m_infl;
      if (c_pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_pend);
      m_infl = c_en;
      if (c_en) begin
        m_pend = word_at(c_addr);
        if (m_phase == 1) begin m_rem1 = m_rem1 - 1; m_addr1 = m_addr1 + 4; end
        else              begin m_rem2 = m_rem2 - 1; m_addr2 = m_addr2 + 4; end
      end
      case (m_phase)
        0: if (start_i) begin
             m_rem1 = size_i;   m_addr1 = address_i;
             m_rem2 = size_2_i; m_addr2 = address_2_i;
             m_phase = (size_i != 0) ? 1 : ((size_2_i != 0) ? 2 : 0);
           end
        1: if (c_en && m_rem1 == 0) m_phase = (m_rem2 != 0) ? 2 : 3;
        2: if (c_en && m_rem2 == 0) m_phase = 3;
        3: if (!c_infl && c_empty) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s1, a1, s2, a2);
    size_i = s1; address_i = a1; size_2_i = s2; address_2_i = a2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (send_active_o && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("idle_timeout", {31'b0, send_active_o}, 32'h0);
    repeat (2) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_active"}, {31'b0, send_active_o}, 32'h0);
    check({tag, "_mem_en"}, {31'b0, mem_en_o},      32'h0);
    check({tag, "_addr"},   mem_addr_o,             32'h0);
    check({tag, "_tx"},     {31'b0, noc_tx_o},      32'h0);
    check({tag, "_data"},   noc_data_o,             32'h0);
  endtask

  task automatic clear_log();
    got.delete();
    reads = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] s1, s2, a1, a2;

    repeat (3) tick();
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    repeat (2) tick();

    // Single segment, free-flowing credit.
    clear_log();
    size_i = 4; address_i = 32'h100; size_2_i = 0; address_2_i = 0;
    start_i = 1'b1;
    check("t1_active_before", {31'b0, send_active_o}, 32'h0);
    tick();
    start_i = 1'b0;
    check("t1_active_rise", {31'b0, send_active_o}, 32'h1);
    wait_idle(200);
    check("t1_reads", reads, 4);
    check("t1_flits", got.size(), 4);
    check("t1_flit0", got[0], 32'hC0DE_0100);
    check("t1_flit3", got[3], 32'hC0DE_010C);

    // Two segments.
    clear_log();
    send(2, 32'h0, 3, 32'h2000);
    wait_idle(200);
    check("t2_reads", reads, 5);
    check("t2_flits", got.size(), 5);
    check("t2_flit1", got[1], 32'hC0DE_0004);
    check("t2_flit2", got[2], 32'hC0DE_2000);
    check("t2_flit4", got[4], 32'hC0DE_2008);

    // Backpressure: credit low for 50 cycles.
    clear_log();
    credit_fix = 1'b0;
    send(40, 32'h4000, 0, 0);
    repeat (50) tick();
    check("t3_stalled_reads", reads, BS);
    check("t3_stalled_tx", {31'b0, noc_tx_o}, 32'h1);
    check("t3_stalled_flits", got.size(), 0);
    credit_fix = 1'b1;
    wait_idle(500);
    check("t3_reads", reads, 40);
    check("t3_flits", got.size(), 40);
    check("t3_flit16", got[16], 32'hC0DE_4040);
    check("t3_flit39", got[39], 32'hC0DE_409C);

    // Zero sizes.
    clear_log();
    send(0, 32'h100, 0, 32'h200);
    check("t4_active", {31'b0, send_active_o}, 32'h0);
    repeat (10) tick();
    check("t4_reads", reads, 0);
    send(0, 32'h100, 2, 32'h300);
    wait_idle(200);
    check("t4b_reads", reads, 2);
    check("t4b_flits", got.size(), 2);
    check("t4b_flit0", got[0], 32'hC0DE_0300);

    // Second start during activity is ignored.
    clear_log();
    send(6, 32'h500, 0, 0);
    repeat (3) tick();
    send(20, 32'h900, 5, 32'hA00);
    wait_idle(200);
    check("t5_flits", got.size(), 6);
    check("t5_flit5", got[5], 32'hC0DE_0514);

    // Reset in the middle of a 10-flit transfer.
    clear_log();
    send(10, 32'h600, 0, 0);
    n = 0;
    while (got.size() < 3 && n < 100) begin tick(); n++; end
    check("t6_reached_flit3", {31'b0, got.size() >= 3}, 32'h1);
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (2) tick();
    clear_log();
    send(3, 32'h700, 0, 0);
    wait_idle(200);
    check("t6_flits", got.size(), 3);
    check("t6_flit0", got[0], 32'hC0DE_0700);
    check("t6_flit2", got[2], 32'hC0DE_0708);

    // Randomised transfers with random credit and occasional ignored starts.
    rand_credit = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s1 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
      s2 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
      a1 = (i % 8 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      a2 = $urandom & 32'hFFFF_FFFC;
      clear_log();
      send(s1, a1, s2, a2);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 5)) tick();
        if (send_active_o) send(32'($urandom_range(1, 9)), 32'h10, 32'd3, 32'h20);
      end
      wait_idle(2000);
      check("rand_flit_count", got.size(), s1 + s2);
    end
    rand_credit = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
